// File: rtl/bcd_pkg.sv
// bcd_pkg: definitions shared by both ends of the signed-value display path.
//   state_t     - conversion FSM states (IDLE, CONV, FINISH)
//   bcd_digit_t - one packed BCD digit (4 bits)
//   DIGIT_MAX   - largest legal BCD digit value
//   acc_width() - accumulator width that holds any DIGITS-digit decimal value
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FINISH = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t DIGIT_MAX = 4'd9;

  // Smallest n with 2^n >= 10^digits, so 10^digits - 1 always fits.
  // Never narrower than a digit, so one digit can always be added.
  function automatic int acc_width(input int digits);
    longint unsigned lim;
    int w;
    lim = 64'd1;
    w   = 0;
    for (int i = 0; i < digits; i++) lim = lim * 64'd10;
    while ((64'd1 << w) < lim) w++;
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/bcd_to_2c_mac.sv
// bcd_digit_mac: combinational decimal shift-and-add step.
//   acc      in  ACC_W  running magnitude
//   digit    in  4      next BCD digit
//   acc_next out ACC_W  acc*10 + digit (an illegal digit contributes 0)
//   bad      out 1      digit is above DIGIT_MAX
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int ACC_W = 14
) (
  input  logic [ACC_W-1:0] acc,
  input  bcd_digit_t       digit,
  output logic [ACC_W-1:0] acc_next,
  output logic             bad
);

  logic [ACC_W-1:0] addend;

  assign bad    = (digit > DIGIT_MAX);
  assign addend = bad ? '0 : ACC_W'(digit);

  // acc*10 as acc*8 + acc*2 keeps this a pair of adders, no multiplier.
  assign acc_next = (acc << 3) + (acc << 1) + addend;

endmodule

// File: rtl/bcd_to_2c.sv
// bcd_to_2c: sequential sign + packed-BCD to two's-complement decoder.
// One digit per clock, most significant digit first; latency DIGITS+1.
//   clk    in   1         system clock, rising edge
//   reset  in   1         synchronous, active-high
//   start  in   1         request conversion (sampled only when idle)
//   sign   in   1         1 = negative magnitude
//   bcd    in   4*DIGITS  packed BCD magnitude, MSD in the top nibble
//   Dout   out  W         two's-complement result, held until next done
//   done   out  1         one-cycle pulse when Dout/err update
//   busy   out  1         conversion in progress, including the done cycle
//   err    out  1         bad digit or magnitude out of range (Dout forced 0)
module bcd_to_2c
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sign,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic signed [W-1:0]   Dout,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);

  localparam int ACC_W = acc_width(DIGITS);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // Range checks and negation run at the wider of accumulator and output,
  // so neither the limits nor the magnitude get truncated.
  localparam int CMP_W = (ACC_W > W) ? ACC_W : W;
  localparam logic [CMP_W-1:0] MAXN = CMP_W'(1) << (W - 1);
  localparam logic [CMP_W-1:0] MAXP = MAXN - CMP_W'(1);

  function automatic logic range_err(input logic neg, input logic [CMP_W-1:0] mag);
    return neg ? (mag > MAXN) : (mag > MAXP);
  endfunction

  function automatic logic [W-1:0] to_twos(input logic neg, input logic [CMP_W-1:0] mag);
    logic [CMP_W-1:0] r;
    r = neg ? (~mag + CMP_W'(1)) : mag;
    return r[W-1:0];
  endfunction

  state_t              state, state_next;
  logic                sign_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [ACC_W-1:0]    acc, acc_next;
  logic [IDX_W-1:0]    idx;
  logic                bad_q;
  logic                digit_bad;
  bcd_digit_t          digit;
  logic [CMP_W-1:0]    acc_ext;
  logic                result_err;

  // Digits come from the captured copy so input changes mid-conversion
  // cannot leak into the result.
  assign digit      = bcd_q[4*idx +: 4];
  assign acc_ext    = CMP_W'(acc);
  assign result_err = bad_q | range_err(sign_q, acc_ext);

  bcd_digit_mac #(
    .ACC_W (ACC_W)
  ) u_mac (
    .acc      (acc),
    .digit    (digit),
    .acc_next (acc_next),
    .bad      (digit_bad)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (idx == '0) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sign_q <= 1'b0;
      bcd_q  <= '0;
      acc    <= '0;
      idx    <= '0;
      bad_q  <= 1'b0;
      Dout   <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          // busy follows acceptance; it stays high straight through a
          // back-to-back start issued during the done cycle.
          busy <= start;
          if (start) begin
            sign_q <= sign;
            bcd_q  <= bcd;
            acc    <= '0;
            idx    <= IDX_W'(DIGITS - 1);
            bad_q  <= 1'b0;
          end
        end
        CONV: begin
          acc   <= acc_next;
          bad_q <= bad_q | digit_bad;
          if (idx != '0) idx <= idx - IDX_W'(1);
        end
        FINISH: begin
          done <= 1'b1;
          err  <= result_err;
          Dout <= result_err ? '0 : to_twos(sign_q, acc_ext);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bcd_to_2c.md
# bcd_to_2c

Sequential decoder that converts a sign flag plus a packed BCD magnitude (the format our signed-value display path produces) back into a W-bit two's-complement value. It processes one BCD digit per clock, most significant digit first. It sits between keypad/switch entry logic, which supplies digits and a sign, and the datapath, which consumes signed bytes. A start/done handshake frames each conversion, and illegal digits or out-of-range magnitudes are flagged.

## Interface
- DIGITS, 4, number of packed BCD digits on `bcd`
- W, 8, output two's-complement width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request conversion; sampled only in IDLE
- sign  in  1  1 = negative magnitude
- bcd  in  4*DIGITS  packed BCD magnitude, digit DIGITS-1 in MSBs
- Dout  out  W  two's-complement result, held until next done
- done  out  1  one-cycle pulse when Dout/err update
- busy  out  1  high from the edge after start acceptance until the done edge, inclusive of the done cycle
- err  out  1  result invalid (bad digit or out of range); held with Dout

## Operation
- States: IDLE, CONV, FINISH.
- IDLE with start=1: capture `sign` and `bcd` into registers, clear the accumulator and digit index, clear the sticky bad-digit flag, then go to CONV. IDLE with start=0: stay.
- CONV, one digit per cycle, MSD first: acc <= acc*10 + digit. If digit > 9, set sticky bad-digit and add 0 for that digit. After digit 0 is processed, go to FINISH.
- FINISH: compute the result.
  - Range limits are MAXP = 2^(W-1)-1 and MAXN = 2^(W-1).
  - err = bad_digit OR (sign=0 AND acc>MAXP) OR (sign=1 AND acc>MAXN).
  - If err: Dout <= 0.
  - Else if sign=1: Dout <= (~acc + 1) truncated to W bits.
  - Else: Dout <= acc[W-1:0].
  - Pulse done, then return to IDLE.
- Accumulator width is ceil(log2(10^DIGITS)), which is 14 for DIGITS=4. It never overflows.
- Negative zero (sign=1, magnitude 0) gives Dout=0, err=0.
- start while busy is ignored and not queued.
- Inputs are captured at acceptance. Later changes to `bcd` or `sign` do not affect the conversion in progress.

## Timing
- Reset values: Dout=0, done=0, busy=0, err=0, state IDLE, accumulator 0.
- Reset asserted mid-conversion: abort on that edge, go to IDLE, and produce no done pulse.
- Start is accepted at edge k. CONV occupies edges k+1 through k+DIGITS. FINISH updates Dout, err and done at edge k+DIGITS+1. Latency is DIGITS+1 cycles (5 for the defaults).
- done is high for exactly one cycle. busy is low in the cycle after done.
- Back-to-back operation: start held high in the cycle after done is accepted immediately. Throughput is one conversion per DIGITS+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `bcd_pkg` holds:
  - the state enum (IDLE, CONV, FINISH)
  - the BCD digit typedef (4 bits) and the DIGIT_MAX=9 constant
  - a function that returns the accumulator width for a given DIGITS
- The package is shared with the display-side converter so both ends use identical digit encoding.
- One sub-module is natural: `bcd_digit_mac`, a combinational acc*10+digit with a bad-digit output. It is implemented as (acc<<3)+(acc<<1)+digit and instantiated once.
- The FSM, capture registers and result formatting live in the top module.

## Test plan
- sign=0, bcd=0x0010, start pulse -> after 5 cycles done=1, Dout=0x0A, err=0. Then sign=1, bcd=0x0010 -> Dout=0xF6.
- Range edges:
  - sign=0, 0x0127 -> 0x7F, err=0.
  - sign=1, 0x0128 -> 0x80, err=0.
  - sign=0, 0x0128 -> err=1, Dout=0.
  - sign=1, 0x0129 -> err=1.
- sign=0, bcd=0x00A5 (illegal digit) -> err=1, Dout=0. Next conversion of 0x0005 -> 0x05, err=0 (sticky flag cleared on start).
- Sequence 20, -20, 5, -5 with start re-pulsed on each done -> 0x14, 0xEC, 0x05, 0xFB, each 5 cycles after its accepted start. Changing `bcd` during CONV does not alter the result.
- start pulses while busy -> ignored, exactly one done per accepted start. sign=1, bcd=0 -> Dout=0, err=0.
- reset asserted in the third CONV cycle -> no done; all outputs are 0 on the following cycle; a fresh start then converts normally.
